// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// A load/store port normally wins over instruction fetch. A saturating
// starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// denials. Read data comes back one cycle after the grant and is routed to
// the port that made the request.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  owner_e     owner_q, owner_d;
  logic       if_gnt, dm_gnt;

  // Grant decision; reset masks both grants so nothing reaches memory.
  always_comb begin
    dm_gnt = rst_i & dm_req_i & (starve_cnt_q < LIMIT);
    if_gnt = rst_i & if_req_i & ~dm_gnt;
  end

  // Memory-side mux: winner's address/data, all zero when idle.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (dm_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end else if (if_gnt) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = if_addr_i;
    end
  end

  // Next starvation count and response owner.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (dm_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (dm_gnt && !dm_we_i) begin
      owner_d = OWN_DM;
    end
  end

  // State registers; async reset clears any response in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_q <= 4'd0;
      owner_q      <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign dm_gnt_o    = dm_gnt;
  assign if_rvalid_o = (owner_q == OWN_IF);
  assign dm_rvalid_o = (owner_q == OWN_DM);
  assign if_rdata_o  = (owner_q == OWN_IF) ? mem_rdata_i : '0;
  assign dm_rdata_o  = (owner_q == OWN_DM) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: fetch, store priority, starvation,
// back-to-back loads, asynchronous reset mid-response and idle behaviour.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [DW-1:0] dm_rdata_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  int n_checks;
  int n_fail;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_rdata_i = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_i = 1'b1;
    #1 rst_i = 1'b0;

    // Reset with requests active: everything forced to zero.
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h44;
    dm_req_i = 1'b1; dm_addr_i = 32'h88; dm_wdata_i = 32'h99; dm_we_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    #1;
    chk("rst_if_gnt", 64'(if_gnt_o), 64'd0);
    chk("rst_dm_gnt", 64'(dm_gnt_o), 64'd0);
    chk("rst_mem_bus", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, 64'd0);
    chk("rst_rvalid", {if_rvalid_o, dm_rvalid_o}, 64'd0);
    chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
    chk("rst_starve", 64'(dut.starve_cnt_q), 64'd0);

    // Release reset and request a fetch in the same cycle.
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    #1;
    chk("fetch_gnt", {if_gnt_o, dm_gnt_o}, 64'b10);
    chk("fetch_addr", 64'(mem_addr_o), 64'h10);
    chk("fetch_en_we", {mem_en_o, mem_we_o}, 64'b10);
    @(negedge clk_i);
    if_req_i = 1'b0; if_addr_i = '0;
    mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("fetch_rvalid", {if_rvalid_o, dm_rvalid_o}, 64'b10);
    chk("fetch_rdata", 64'(if_rdata_o), 64'hDEAD_BEEF);
    chk("fetch_dm_rdata", 64'(dm_rdata_o), 64'd0);
    chk("fetch_idle_en", 64'(mem_en_o), 64'd0);

    // Store wins over a concurrent fetch and produces no response.
    @(negedge clk_i);
    mem_rdata_i = '0;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'h5;
    #1;
    chk("store_gnt", {if_gnt_o, dm_gnt_o}, 64'b01);
    chk("store_bus", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, {2'b11, 32'h100, 32'h5});
    @(negedge clk_i);
    idle_inputs();
    mem_rdata_i = 32'h77;
    #1;
    chk("store_rvalid", {if_rvalid_o, dm_rvalid_o}, 64'b00);
    chk("store_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);

    // Starvation: both held; dm x4, if x1, repeating.
    @(negedge clk_i);
    mem_rdata_i = '0;
    #1;
    chk("starve_clear_idle", 64'(dut.starve_cnt_q), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if_req_i = 1'b1; if_addr_i = 32'h300;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h400; dm_wdata_i = 32'(i);
      #1;
      chk($sformatf("starve_gnt_%0d", i), {if_gnt_o, dm_gnt_o},
          (i % 5 == 4) ? 64'b10 : 64'b01);
      chk($sformatf("starve_cnt_%0d", i), 64'(dut.starve_cnt_q), 64'(i % 5));
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("starve_if_resp", {if_rvalid_o, dm_rvalid_o}, 64'b00);

    // Back-to-back loads, responses in grant order.
    @(negedge clk_i);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    #1;
    chk("ld0_gnt", {dm_gnt_o, mem_we_o, mem_addr_o}, {2'b10, 32'h200});
    @(negedge clk_i);
    dm_addr_i = 32'h204; mem_rdata_i = 32'hA;
    #1;
    chk("ld1_gnt", {dm_gnt_o, mem_we_o, mem_addr_o}, {2'b10, 32'h204});
    chk("ld0_resp", {if_rvalid_o, dm_rvalid_o, dm_rdata_o}, {2'b01, 32'hA});
    @(negedge clk_i);
    idle_inputs();
    mem_rdata_i = 32'hB;
    #1;
    chk("ld1_resp", {if_rvalid_o, dm_rvalid_o, dm_rdata_o}, {2'b01, 32'hB});
    @(negedge clk_i);
    mem_rdata_i = 32'hC;
    #1;
    chk("ld_done", {dm_rvalid_o, dm_rdata_o}, 64'd0);

    // Async reset right after a fetch grant kills the response.
    @(negedge clk_i);
    idle_inputs();
    if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b1;
    #1;
    chk("pre_rst_dm_gnt", 64'(dm_gnt_o), 64'd1);
    @(negedge clk_i);
    dm_req_i = 1'b0; if_addr_i = 32'h40;
    #1;
    chk("pre_rst_if_gnt", 64'(if_gnt_o), 64'd1);
    @(posedge clk_i);
    #2;
    mem_rdata_i = 32'hCAFE_F00D;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_rvalid", {if_rvalid_o, dm_rvalid_o}, 64'b00);
    chk("rst_mid_rdata", 64'(if_rdata_o), 64'd0);
    chk("rst_mid_gnt", {if_gnt_o, dm_gnt_o, mem_en_o}, 64'd0);
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk("rst_rel_starve", 64'(dut.starve_cnt_q), 64'd0);
    chk("rst_rel_rvalid", {if_rvalid_o, dm_rvalid_o}, 64'b00);

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk($sformatf("idle_%0d", i),
          {mem_en_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, dut.starve_cnt_q}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
